// File: rtl/tdm_pkg.sv
// Shared constants for the two-lane TDM serial demultiplexer.
// TDM_DEMUX_PARITY_EN adds one even-parity bit to the end of every word.
package tdm_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  localparam int NUM_LANES = 2;

  // Serial bits per word on the wire, including the parity bit when present.
  function automatic int bits_per_word(input int width);
`ifdef TDM_DEMUX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/tdm_demux_lane.sv
// One demux lane: serial-to-parallel shift, bit counter, one-word holding register and stall.
// TDM_DEMUX_PARITY_EN: the word ends with a parity bit that is checked, not stored.
module tdm_demux_lane
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take,
  input  logic             in_bit,
  input  logic             out_ready,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int BITS = bits_per_word(WIDTH);
  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             accept;
  logic             word_done;
  logic             shift_en;

  assign last_bit  = (cnt == LAST);
  // Only the final bit can stall: it needs the holding register free (or draining now).
  assign stall     = last_bit && out_valid && !out_ready;
  assign accept    = take && !stall;
  assign word_done = accept && last_bit;

`ifdef TDM_DEMUX_PARITY_EN
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic             err_q;

  assign word      = shift;
  assign shift_en  = accept && !last_bit;
  assign shift_nxt = {shift[WIDTH-2:0], in_bit};
  assign out_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (word_done) begin
      err_q <= ^{shift, in_bit};
    end
  end
`else
  // The final data bit goes straight into the holding register, so the
  // shift register only needs the leading WIDTH-1 bits.
  logic [WIDTH-2:0] shift;
  logic [WIDTH-2:0] shift_nxt;

  assign word      = {shift, in_bit};
  assign shift_en  = accept;
  assign shift_nxt = word[WIDTH-2:0];
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shift     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        cnt <= last_bit ? '0 : cnt + CW'(1);
      end
      if (shift_en) begin
        shift <= shift_nxt;
      end
      if (word_done) begin
        out_valid <= 1'b1;
        out_data  <= word;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Two-channel TDM serial demultiplexer: in_sel steers each bit to its lane.
// TDM_DEMUX_PARITY_EN enables per-word even-parity checking on out_err.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [1:0]       out_err
);

  logic [NUM_LANES-1:0] stall;
  logic [NUM_LANES-1:0] err;

  assign in_ready = !stall[in_sel];
  assign out_err  = err;

  tdm_demux_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk       (clk),
    .rst       (rst),
    .take      (in_valid && (in_sel == CH0)),
    .in_bit    (in_bit),
    .out_ready (out0_ready),
    .stall     (stall[0]),
    .out_valid (out0_valid),
    .out_data  (out0_data),
    .out_err   (err[0])
  );

  tdm_demux_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .take      (in_valid && (in_sel == CH1)),
    .in_bit    (in_bit),
    .out_ready (out1_ready),
    .stall     (stall[1]),
    .out_valid (out1_valid),
    .out_data  (out1_data),
    .out_err   (err[1])
  );

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (WIDTH = 8); builds with or without TDM_DEMUX_PARITY_EN.
module tb_tdm_demux;

  localparam int WIDTH = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int BPW = 9;
`else
  localparam int BPW = 8;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_bit, in_sel, in_ready;
  logic       out0_valid, out1_valid, out0_ready, out1_ready;
  logic [7:0] out0_data, out1_data;
  logic [1:0] out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .out_err    (out_err)
  );

  typedef struct {
    logic       ch;
    logic [7:0] word;
    logic       par;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic ch, input logic b);
    in_valid = 1'b1;
    in_sel   = ch;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Sends the first nbits of the serial stream {word, par}, MSB first.
  task automatic send_partial(input logic ch, input logic [7:0] w, input logic p, input int nbits);
    logic [8:0] bits;
    bits = {w, p};
    for (int k = 0; k < nbits; k++) send_bit(ch, bits[8-k]);
  endtask

  task automatic send_word(input logic ch, input logic [7:0] w, input logic p);
    send_partial(ch, w, p, BPW);
  endtask

  task automatic chk_lane(input string name, input logic ch, input logic v, input logic [7:0] d);
    chk({name, "_valid"}, ch ? out1_valid : out0_valid, v);
    chk({name, "_data"}, ch ? out1_data : out0_data, d);
  endtask

  initial begin
    logic [8:0] bits;
    logic [8:0] bits_a;
    logic [8:0] bits_b;
    vecs[0] = '{ch: 1'b0, word: 8'hA5, par: 1'b0, exp_data: 8'hA5};
    vecs[1] = '{ch: 1'b1, word: 8'h5A, par: 1'b0, exp_data: 8'h5A};
    vecs[2] = '{ch: 1'b0, word: 8'h00, par: 1'b0, exp_data: 8'h00};
    vecs[3] = '{ch: 1'b0, word: 8'hFF, par: 1'b0, exp_data: 8'hFF};
    vecs[4] = '{ch: 1'b1, word: 8'h81, par: 1'b0, exp_data: 8'h81};
    vecs[5] = '{ch: 1'b1, word: 8'h01, par: 1'b1, exp_data: 8'h01};

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset held two cycles
    tick(); tick();
    chk("rst_out0_valid", out0_valid, 1'b0);
    chk("rst_out1_valid", out1_valid, 1'b0);
    chk("rst_out0_data", out0_data, 8'h00);
    chk("rst_out1_data", out1_data, 8'h00);
    chk("rst_out_err", out_err, 2'b00);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single words per channel, consumer always ready
    foreach (vecs[i]) begin
      send_partial(vecs[i].ch, vecs[i].word, vecs[i].par, BPW - 1);
      chk_lane($sformatf("v%0d_pre", i), vecs[i].ch, 1'b0, 8'h00 | (vecs[i].ch ? out1_data : out0_data));
      chk($sformatf("v%0d_pre_valid", i), vecs[i].ch ? out1_valid : out0_valid, 1'b0);
      bits = {vecs[i].word, vecs[i].par};
      send_bit(vecs[i].ch, bits[9-BPW]);
      chk_lane($sformatf("v%0d", i), vecs[i].ch, 1'b1, vecs[i].exp_data);
      chk($sformatf("v%0d_other_valid", i), vecs[i].ch ? out0_valid : out1_valid, 1'b0);
      chk($sformatf("v%0d_err", i), out_err, 2'b00);
      tick();
      chk($sformatf("v%0d_drained", i), vecs[i].ch ? out1_valid : out0_valid, 1'b0);
    end

    // Bit-by-bit alternation, both words held until both complete
    out0_ready = 1'b0; out1_ready = 1'b0;
    bits_a = {8'hF0, 1'b0};
    bits_b = {8'h3C, 1'b0};
    for (int k = 0; k < BPW; k++) begin
      send_bit(1'b0, bits_a[8-k]);
      send_bit(1'b1, bits_b[8-k]);
    end
    chk_lane("alt_ch0", 1'b0, 1'b1, 8'hF0);
    chk_lane("alt_ch1", 1'b1, 1'b1, 8'h3C);
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    chk("alt_drain0", out0_valid, 1'b0);
    chk("alt_drain1", out1_valid, 1'b0);

    // Back-pressure on channel 1 with a second word queued behind the first
    out1_ready = 1'b0;
    send_word(1'b1, 8'h11, 1'b0);
    chk_lane("bp_first", 1'b1, 1'b1, 8'h11);
    tick();
    chk_lane("bp_hold", 1'b1, 1'b1, 8'h11);
    send_partial(1'b1, 8'h22, 1'b0, BPW - 1);
    bits = {8'h22, 1'b0};
    in_valid = 1'b1; in_sel = 1'b1; in_bit = bits[9-BPW];
    #1;
    chk("bp_ready_sel1", in_ready, 1'b0);
    in_valid = 1'b0; in_sel = 1'b0;
    #1;
    chk("bp_ready_sel0", in_ready, 1'b1);
    in_valid = 1'b1; in_sel = 1'b1;
    tick();
    chk_lane("bp_stalled", 1'b1, 1'b1, 8'h11);
    out1_ready = 1'b1;
    #1;
    chk("bp_ready_release", in_ready, 1'b1);
    chk_lane("bp_drain_first", 1'b1, 1'b1, 8'h11);
    tick();
    in_valid = 1'b0;
    chk_lane("bp_second", 1'b1, 1'b1, 8'h22);
    tick();
    chk("bp_empty", out1_valid, 1'b0);

    // Reset mid-word discards the partial word
    send_partial(1'b0, 8'hC3, 1'b0, 4);
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    chk("midrst_valid", out0_valid, 1'b0);
    send_partial(1'b0, 8'h5A, 1'b0, BPW - 1);
    chk("midrst_pre_valid", out0_valid, 1'b0);
    send_bit(1'b0, bits_last(8'h5A, 1'b0));
    chk_lane("midrst_word", 1'b0, 1'b1, 8'h5A);
    tick();
    chk("midrst_single", out0_valid, 1'b0);

    // Reset while a word is held: no valid afterwards
    out0_ready = 1'b0;
    send_word(1'b0, 8'h3C, 1'b0);
    chk_lane("heldrst_before", 1'b0, 1'b1, 8'h3C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_lane("heldrst_after", 1'b0, 1'b0, 8'h00);
    tick();
    chk("heldrst_still", out0_valid, 1'b0);
    out0_ready = 1'b1;

    // Parity: 0x07 has three ones
    out0_ready = 1'b0;
    send_word(1'b0, 8'h07, 1'b1);
    chk_lane("par_good", 1'b0, 1'b1, 8'h07);
    chk("par_good_err", out_err, 2'b00);
    out0_ready = 1'b1;
    tick();
    send_word(1'b0, 8'h07, 1'b0);
    chk_lane("par_bad", 1'b0, 1'b1, 8'h07);
`ifdef TDM_DEMUX_PARITY_EN
    chk("par_bad_err", out_err, 2'b01);
`else
    chk("par_bad_err", out_err, 2'b00);
`endif
    tick();
    chk("par_drained", out0_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic bits_last(input logic [7:0] w, input logic p);
    logic [8:0] b;
    b = {w, p};
    return b[9-BPW];
  endfunction

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per word per channel (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  serial bit present on in_bit this cycle.
REQ-005 in_bit  input  1  serial data bit, MSB-first.
REQ-006 in_sel  input  1  channel tag of in_bit: 0 = channel 0, 1 = channel 1.
REQ-007 in_ready  output  1  block accepts in_bit for channel in_sel this cycle.
REQ-008 out0_valid / out1_valid  output  1  channel word held and presented.
REQ-009 out0_data / out1_data  output  WIDTH  channel word.
REQ-010 out0_ready / out1_ready  input  1  consumer takes channel word.
REQ-011 out_err  output  2  per-channel parity error, qualified by the matching outN_valid.

Function
REQ-012 Bit accepted for lane L when in_valid && in_ready && in_sel==L; other lane unaffected.
REQ-013 Each lane: shift register, bit counter, one-word holding register, holding-valid flag.
REQ-014 Accepted bit: shift register <= {shift[WIDTH-2:0], in_bit}; counter increments.
REQ-015 Final bit of a word (counter at last position) accepted in cycle t: holding register loads the completed word, outL_valid = 1 from cycle t+1, counter returns to 0.
REQ-016 outL_valid stays 1 with stable outL_data/out_err[L] until outL_ready sampled high; cleared next cycle unless a new word loads in the same cycle.
REQ-017 Simultaneous drain (outL_valid && outL_ready) and final-bit acceptance on lane L: new word loads, outL_valid remains 1 (no bubble).
REQ-018 Stall: lane L stalled when counter at last position, outL_valid = 1, outL_ready = 0.
REQ-019 in_ready = NOT stall[in_sel]; combinational; non-final bits never stalled.
REQ-020 Lanes fully independent; arbitrary interleaving of in_sel legal, including bit-by-bit alternation.
REQ-021 in_valid = 0: no state change except drain per REQ-016.

Reset
REQ-022 rst high at a clock edge: counters 0, shift and holding registers 0, out0_valid = out1_valid = 0, out_err = 0, out0_data = out1_data = 0.
REQ-023 in_ready = 1 during and after reset.
REQ-024 Reset mid-word discards the partial word; next accepted bit is MSB of a new word.
REQ-025 Reset with word held: word discarded, no valid pulse.

Configuration
REQ-026 Macro TDM_DEMUX_PARITY_EN.
REQ-027 Defined: each word = WIDTH data bits then one even-parity bit; word completes on parity bit; parity bit not stored; out_err[L] = 1 when XOR(data bits, parity bit) = 1.
REQ-028 Undefined: word = WIDTH data bits; out_err tied 0; port list identical in both builds.

Structure
REQ-029 Shared package tdm_pkg: WIDTH default, channel-ID constants CH0 = 1'b0 and CH1 = 1'b1, lane-count constant 2.
REQ-030 One sub-module tdm_demux_lane (shift, counter, holding, stall), instantiated twice; top holds only in_ready select and port wiring.

Verification (WIDTH = 8)
REQ-031 Reset: rst = 1 two cycles -> all outputs 0, in_ready = 1.
REQ-032 Channel 0, bits of 0xA5 consecutively, out0_ready = 1 -> out0_valid high exactly one cycle, starting one cycle after 8th bit, out0_data = 0xA5; out1_valid stays 0.
REQ-033 Alternating in_sel per bit, 0xF0 on channel 0 and 0x3C on channel 1 -> out0_data = 0xF0, out1_data = 0x3C, both valid in the same cycle.
REQ-034 out1_ready = 0, send 0x11 then 0x22 on channel 1 -> 0x22 final bit sees in_ready = 0 while in_sel = 1, in_ready = 1 when in_sel = 0; raise out1_ready -> 0x11, then 0x22 next cycle, no bubble.
REQ-035 4 bits on channel 0, rst one cycle, then 0x5A -> single out0_valid with 0x5A.
REQ-036 TDM_DEMUX_PARITY_EN: 0x07 + parity 1 -> out_err[0] = 0; 0x07 + parity 0 -> out_err[0] = 1; undefined build: out_err always 0.
